// File: rtl/sprite_rom_arbiter.sv
// Four-requester sprite ROM arbiter: round-robin or fixed-priority grant,
// registered ROM strobe/address, and a one-hot tag pipeline that routes read data back to its owner.
module sprite_rom_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned ROM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [4*ADDR_W-1:0]   addr,
    input  logic                  prio_en,
    output logic [3:0]            gnt,
    output logic                  rom_en,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic [DATA_W-1:0]     rdata,
    output logic [3:0]            rvalid
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    logic [IDX_W-1:0]           ptr;
    logic [IDX_W-1:0]           win_idx;
    logic [IDX_W-1:0]           cand;
    logic                       win_any;
    logic [ROM_LAT:0][N_REQ-1:0] tag_pipe;

    // Winner selection; loops run from lowest to highest priority so the last hit wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        cand    = '0;
        gnt     = '0;
        if (prio_en) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win_any = 1'b1;
                    win_idx = IDX_W'(i);
                end
            end
        end else begin
            // k = 4 wraps back to ptr itself, the last position in the search order
            for (int k = N_REQ; k >= 1; k--) begin
                cand = ptr + IDX_W'(k);
                if (req[cand]) begin
                    win_any = 1'b1;
                    win_idx = cand;
                end
            end
        end
        if (win_any) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // Every edge with a nonzero grant is a transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= IDX_W'(3);
            rom_en   <= 1'b0;
            rom_addr <= '0;
            tag_pipe <= '0;
            rdata    <= '0;
            rvalid   <= '0;
        end else begin
            rom_en   <= win_any;
            if (win_any) begin
                ptr      <= win_idx;
                rom_addr <= addr[win_idx*ADDR_W +: ADDR_W];
            end
            tag_pipe <= {tag_pipe[ROM_LAT-1:0], gnt};
            rvalid   <= tag_pipe[ROM_LAT];
            if (|tag_pipe[ROM_LAT]) begin
                rdata <= rom_data;
            end
        end
    end

endmodule
